// File: rtl/ikaopm_acc_pkg.sv
// Shared definitions for the R/L accumulator sequencer slice.
//   - sync_state_t    : frame-sync lock FSM states
//   - CYC_*           : cycle numbers decoded into the accumulator strobes
//   - SAMPLE_W        : width of one channel sample
//   - cyc_strobes_t   : packed bundle of the decoded cycle strobes
//   - decode_cycle()  : maps a counter value onto the strobe bundle
package ikaopm_acc_pkg;

  localparam int unsigned SAMPLE_W = 16;

  localparam logic [4:0] CYC_00 = 5'd0;
  localparam logic [4:0] CYC_06 = 5'd6;
  localparam logic [4:0] CYC_12 = 5'd12;
  localparam logic [4:0] CYC_16 = 5'd16;
  localparam logic [4:0] CYC_22 = 5'd22;
  localparam logic [4:0] CYC_29 = 5'd29;
  localparam logic [4:0] CYC_31 = 5'd31;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } sync_state_t;

  typedef struct packed {
    logic c12;
    logic c29;
    logic c00_16;
    logic c06_22;
    logic c01_to_16;
  } cyc_strobes_t;

  function automatic cyc_strobes_t decode_cycle(input logic [4:0] c);
    cyc_strobes_t s;
    s.c12       = (c == CYC_12);
    s.c29       = (c == CYC_29);
    s.c00_16    = (c == CYC_00) || (c == CYC_16);
    s.c06_22    = (c == CYC_06) || (c == CYC_22);
    s.c01_to_16 = (c >= 5'd1) && (c <= CYC_16);
    return s;
  endfunction

endpackage

// File: rtl/ikaopm_acc_frame_handoff.sv
// Stereo frame pairing and valid/ready handoff.
// Pairs the accumulator's L then R parallel-sample strobes into one stereo
// frame and presents it to a host consumer.
//   i_EMUCLK, i_MRST_n          : clock, synchronous active-low reset
//   i_ERR_CLR                   : clears o_OVERRUN (a same-cycle set wins)
//   i_EMU_L/R_SAMPLE, i_EMU_L/R : sample strobes and parallel samples
//   o_FRAME_VALID/i_FRAME_READY : handshake, o_FRAME_L/R payload
//   o_OVERRUN                   : sticky, a completed frame was dropped
module ikaopm_acc_frame_handoff
  import ikaopm_acc_pkg::*;
(
  input  logic                       i_EMUCLK,
  input  logic                       i_MRST_n,
  input  logic                       i_ERR_CLR,
  input  logic                       i_EMU_R_SAMPLE,
  input  logic                       i_EMU_L_SAMPLE,
  input  logic signed [SAMPLE_W-1:0] i_EMU_R,
  input  logic signed [SAMPLE_W-1:0] i_EMU_L,
  output logic                       o_FRAME_VALID,
  input  logic                       i_FRAME_READY,
  output logic signed [SAMPLE_W-1:0] o_FRAME_L,
  output logic signed [SAMPLE_W-1:0] o_FRAME_R,
  output logic                       o_OVERRUN
);

  logic signed [SAMPLE_W-1:0] l_hold;
  logic                       l_have;
  logic signed [SAMPLE_W-1:0] frame_l, frame_r;
  logic                       valid_q, overrun_q;
  logic                       frame_done, load_ok;

  // An R strobe completes a frame only against an L already held; a
  // same-cycle L strobe is latched afterwards for the next frame.
  assign frame_done = i_EMU_R_SAMPLE && l_have;
  // The output register is free if empty or being drained this cycle.
  assign load_ok    = !valid_q || i_FRAME_READY;

  always_ff @(posedge i_EMUCLK) begin
    if (!i_MRST_n) begin
      l_hold    <= '0;
      l_have    <= 1'b0;
      frame_l   <= '0;
      frame_r   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (i_EMU_L_SAMPLE) begin
        l_hold <= i_EMU_L;
        l_have <= 1'b1;
      end else if (frame_done) begin
        l_have <= 1'b0;
      end

      if (frame_done && load_ok) begin
        frame_l <= l_hold;
        frame_r <= i_EMU_R;
        valid_q <= 1'b1;
      end else if (valid_q && i_FRAME_READY) begin
        valid_q <= 1'b0;
      end

      if (frame_done && !load_ok) begin
        overrun_q <= 1'b1;
      end else if (i_ERR_CLR) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign o_FRAME_VALID = valid_q;
  assign o_FRAME_L     = frame_l;
  assign o_FRAME_R     = frame_r;
  assign o_OVERRUN     = overrun_q;

endmodule

// File: rtl/ikaopm_acc_sequencer.sv
// 32-step phi1 cycle sequencer for the R/L accumulator datapath.
// Locks a free-running cycle counter to the upstream frame-sync pulse,
// decodes registered cycle strobes, and forwards stereo frames to the host
// through ikaopm_acc_frame_handoff.
//   i_EMUCLK, i_MRST_n  : clock, synchronous active-low reset
//   i_phi1_NCEN_n       : active-low phi1 enable for counter/FSM/strobes
//   i_CYCLE_SYNC        : sync pulse marking master cycle 31
//   o_CYCLE_*           : registered cycle strobes, 0 unless locked
//   o_LOCKED, o_SYNC_ERR: lock status, sticky misplaced-sync flag
//   i_ERR_CLR           : clears o_SYNC_ERR and o_OVERRUN
//   i_EMU_*, o_FRAME_*, i_FRAME_READY, o_OVERRUN : frame handoff
module ikaopm_acc_sequencer
  import ikaopm_acc_pkg::*;
#(
  parameter int unsigned SYNC_LOCK_COUNT = 2
) (
  input  logic                       i_EMUCLK,
  input  logic                       i_MRST_n,
  input  logic                       i_phi1_NCEN_n,
  input  logic                       i_CYCLE_SYNC,
  output logic                       o_CYCLE_12,
  output logic                       o_CYCLE_29,
  output logic                       o_CYCLE_00_16,
  output logic                       o_CYCLE_06_22,
  output logic                       o_CYCLE_01_TO_16,
  output logic                       o_LOCKED,
  output logic                       o_SYNC_ERR,
  input  logic                       i_ERR_CLR,
  input  logic                       i_EMU_R_SAMPLE,
  input  logic                       i_EMU_L_SAMPLE,
  input  logic signed [SAMPLE_W-1:0] i_EMU_R,
  input  logic signed [SAMPLE_W-1:0] i_EMU_L,
  output logic                       o_FRAME_VALID,
  input  logic                       i_FRAME_READY,
  output logic signed [SAMPLE_W-1:0] o_FRAME_L,
  output logic signed [SAMPLE_W-1:0] o_FRAME_R,
  output logic                       o_OVERRUN
);

  localparam logic [2:0] LOCK_TARGET = 3'(SYNC_LOCK_COUNT);

  sync_state_t  state, state_nxt;
  logic [4:0]   cyc, cyc_nxt;
  logic [2:0]   lock_cnt, lock_cnt_nxt;
  logic         sync_err_set;
  logic         sync_err_q;
  cyc_strobes_t strb_q, strb_nxt;
  logic         phi_en;

  assign phi_en = !i_phi1_NCEN_n;

  always_comb begin
    cyc_nxt      = cyc + 5'd1;
    lock_cnt_nxt = lock_cnt;
    state_nxt    = state;
    sync_err_set = 1'b0;
    if (i_CYCLE_SYNC) begin
      case (state)
        ST_UNLOCKED: begin
          cyc_nxt      = '0;
          lock_cnt_nxt = 3'd1;
          state_nxt    = (LOCK_TARGET == 3'd1) ? ST_LOCKED : ST_LOCKING;
        end
        ST_LOCKING: begin
          if (cyc == CYC_31) begin
            lock_cnt_nxt = lock_cnt + 3'd1;
            if (lock_cnt + 3'd1 >= LOCK_TARGET) state_nxt = ST_LOCKED;
          end else begin
            cyc_nxt      = '0;
            lock_cnt_nxt = 3'd1;
          end
        end
        ST_LOCKED: begin
          if (cyc != CYC_31) begin
            sync_err_set = 1'b1;
            cyc_nxt      = '0;
            lock_cnt_nxt = 3'd1;
            state_nxt    = ST_LOCKING;
          end
        end
        default: state_nxt = ST_UNLOCKED;
      endcase
    end
    // Decoding the next counter/state keeps each strobe aligned with the
    // phi1 period in which the counter actually holds that value.
    strb_nxt = (state_nxt == ST_LOCKED) ? decode_cycle(cyc_nxt) : '0;
  end

  always_ff @(posedge i_EMUCLK) begin
    if (!i_MRST_n) begin
      state      <= ST_UNLOCKED;
      cyc        <= '0;
      lock_cnt   <= '0;
      strb_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      if (phi_en) begin
        state    <= state_nxt;
        cyc      <= cyc_nxt;
        lock_cnt <= lock_cnt_nxt;
        strb_q   <= strb_nxt;
      end
      if (phi_en && sync_err_set) begin
        sync_err_q <= 1'b1;
      end else if (i_ERR_CLR) begin
        sync_err_q <= 1'b0;
      end
    end
  end

  assign o_CYCLE_12       = strb_q.c12;
  assign o_CYCLE_29       = strb_q.c29;
  assign o_CYCLE_00_16    = strb_q.c00_16;
  assign o_CYCLE_06_22    = strb_q.c06_22;
  assign o_CYCLE_01_TO_16 = strb_q.c01_to_16;
  assign o_LOCKED         = (state == ST_LOCKED);
  assign o_SYNC_ERR       = sync_err_q;

  ikaopm_acc_frame_handoff u_handoff (
    .i_EMUCLK      (i_EMUCLK),
    .i_MRST_n      (i_MRST_n),
    .i_ERR_CLR     (i_ERR_CLR),
    .i_EMU_R_SAMPLE(i_EMU_R_SAMPLE),
    .i_EMU_L_SAMPLE(i_EMU_L_SAMPLE),
    .i_EMU_R       (i_EMU_R),
    .i_EMU_L       (i_EMU_L),
    .o_FRAME_VALID (o_FRAME_VALID),
    .i_FRAME_READY (i_FRAME_READY),
    .o_FRAME_L     (o_FRAME_L),
    .o_FRAME_R     (o_FRAME_R),
    .o_OVERRUN     (o_OVERRUN)
  );

endmodule

// File: tb/tb_ikaopm_acc_sequencer.sv
module tb_ikaopm_acc_sequencer;

  logic i_EMUCLK;
  logic i_MRST_n;
  logic i_phi1_NCEN_n;
  logic i_CYCLE_SYNC;
  logic o_CYCLE_12, o_CYCLE_29, o_CYCLE_00_16, o_CYCLE_06_22, o_CYCLE_01_TO_16;
  logic o_LOCKED, o_SYNC_ERR;
  logic i_ERR_CLR;
  logic i_EMU_R_SAMPLE, i_EMU_L_SAMPLE;
  logic signed [15:0] i_EMU_R, i_EMU_L;
  logic o_FRAME_VALID;
  logic i_FRAME_READY;
  logic signed [15:0] o_FRAME_L, o_FRAME_R;
  logic o_OVERRUN;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  ikaopm_acc_sequencer #(.SYNC_LOCK_COUNT(2)) dut (
    .i_EMUCLK        (i_EMUCLK),
    .i_MRST_n        (i_MRST_n),
    .i_phi1_NCEN_n   (i_phi1_NCEN_n),
    .i_CYCLE_SYNC    (i_CYCLE_SYNC),
    .o_CYCLE_12      (o_CYCLE_12),
    .o_CYCLE_29      (o_CYCLE_29),
    .o_CYCLE_00_16   (o_CYCLE_00_16),
    .o_CYCLE_06_22   (o_CYCLE_06_22),
    .o_CYCLE_01_TO_16(o_CYCLE_01_TO_16),
    .o_LOCKED        (o_LOCKED),
    .o_SYNC_ERR      (o_SYNC_ERR),
    .i_ERR_CLR       (i_ERR_CLR),
    .i_EMU_R_SAMPLE  (i_EMU_R_SAMPLE),
    .i_EMU_L_SAMPLE  (i_EMU_L_SAMPLE),
    .i_EMU_R         (i_EMU_R),
    .i_EMU_L         (i_EMU_L),
    .o_FRAME_VALID   (o_FRAME_VALID),
    .i_FRAME_READY   (i_FRAME_READY),
    .o_FRAME_L       (o_FRAME_L),
    .o_FRAME_R       (o_FRAME_R),
    .o_OVERRUN       (o_OVERRUN)
  );

  initial i_EMUCLK = 1'b0;
  always #5 i_EMUCLK = ~i_EMUCLK;

  typedef struct {
    logic        ls, rs;
    logic [15:0] l, r;
    logic        rdy, clr, push;
    logic [15:0] pl, pr;
    logic        ev;
    logic [15:0] el, er;
    logic        eo;
  } vec_t;

  vec_t rows[$];

  function automatic vec_t mk(input logic ls, input logic rs, input logic [15:0] l,
                              input logic [15:0] r, input logic rdy, input logic clr,
                              input logic push, input logic [15:0] pl, input logic [15:0] pr,
                              input logic ev, input logic [15:0] el, input logic [15:0] er,
                              input logic eo);
    vec_t v;
    v.ls = ls; v.rs = rs; v.l = l; v.r = r; v.rdy = rdy; v.clr = clr;
    v.push = push; v.pl = pl; v.pr = pr; v.ev = ev; v.el = el; v.er = er; v.eo = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_strobes(input int c);
    return {c == 12, c == 29, (c == 0) || (c == 16), (c == 6) || (c == 22),
            (c >= 1) && (c <= 16)};
  endfunction

  function automatic logic [4:0] strobes();
    return {o_CYCLE_12, o_CYCLE_29, o_CYCLE_00_16, o_CYCLE_06_22, o_CYCLE_01_TO_16};
  endfunction

  // One phi1 period = one enabled EMUCLK followed by one idle EMUCLK.
  task automatic phi_step(input logic sync, input logic clr);
    i_phi1_NCEN_n = 1'b0;
    i_CYCLE_SYNC  = sync;
    i_ERR_CLR     = clr;
    @(posedge i_EMUCLK); #1;
    i_phi1_NCEN_n = 1'b1;
    i_CYCLE_SYNC  = 1'b0;
    i_ERR_CLR     = 1'b0;
    @(posedge i_EMUCLK); #1;
  endtask

  task automatic apply_row(input vec_t v, input string tag);
    logic [31:0] exp_frame;
    i_EMU_L_SAMPLE = v.ls;
    i_EMU_R_SAMPLE = v.rs;
    i_EMU_L        = v.l;
    i_EMU_R        = v.r;
    i_FRAME_READY  = v.rdy;
    i_ERR_CLR      = v.clr;
    if (o_FRAME_VALID && v.rdy) begin
      if (sb.size() == 0) begin
        check({tag, "_xfer_unexpected"}, 64'd1, 64'd0);
      end else begin
        exp_frame = sb.pop_front();
        check({tag, "_xfer"}, {o_FRAME_L, o_FRAME_R}, exp_frame);
      end
    end
    if (v.push) sb.push_back({v.pl, v.pr});
    @(posedge i_EMUCLK); #1;
    i_EMU_L_SAMPLE = 1'b0;
    i_EMU_R_SAMPLE = 1'b0;
    i_ERR_CLR      = 1'b0;
    check(tag, {o_FRAME_VALID, o_OVERRUN, o_FRAME_VALID ? {o_FRAME_L, o_FRAME_R} : 32'd0},
          {v.ev, v.eo, v.ev ? {v.el, v.er} : 32'd0});
  endtask

  initial begin
    int exp_cyc;
    int cnt12, cnt_rng;

    i_MRST_n = 1'b0; i_phi1_NCEN_n = 1'b0; i_CYCLE_SYNC = 1'b0; i_ERR_CLR = 1'b0;
    i_EMU_R_SAMPLE = 1'b0; i_EMU_L_SAMPLE = 1'b0; i_EMU_R = '0; i_EMU_L = '0;
    i_FRAME_READY = 1'b0;

    // Frame handoff vectors, applied in order after the sequencer tests.
    rows.push_back(mk(0,1,16'h0000,16'h1111,1,0, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,0));
    rows.push_back(mk(1,0,16'h2222,16'h0000,1,0, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,0));
    rows.push_back(mk(0,1,16'h0000,16'h3333,1,0, 1,16'h2222,16'h3333, 1,16'h2222,16'h3333,0));
    rows.push_back(mk(0,0,16'h0000,16'h0000,1,0, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,0));
    rows.push_back(mk(1,0,16'h1234,16'h0000,1,0, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,0));
    rows.push_back(mk(0,1,16'h0000,16'hFEDC,1,0, 1,16'h1234,16'hFEDC, 1,16'h1234,16'hFEDC,0));
    rows.push_back(mk(0,0,16'h0000,16'h0000,1,0, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,0));
    rows.push_back(mk(1,0,16'h0AAA,16'h0000,0,0, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,0));
    rows.push_back(mk(0,1,16'h0000,16'h0BBB,0,0, 1,16'h0AAA,16'h0BBB, 1,16'h0AAA,16'h0BBB,0));
    rows.push_back(mk(1,0,16'h0CCC,16'h0000,0,0, 0,16'h0000,16'h0000, 1,16'h0AAA,16'h0BBB,0));
    rows.push_back(mk(0,1,16'h0000,16'h0DDD,0,0, 0,16'h0000,16'h0000, 1,16'h0AAA,16'h0BBB,1));
    rows.push_back(mk(0,0,16'h0000,16'h0000,0,0, 0,16'h0000,16'h0000, 1,16'h0AAA,16'h0BBB,1));
    rows.push_back(mk(0,0,16'h0000,16'h0000,1,0, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,1));
    rows.push_back(mk(1,0,16'h0111,16'h0000,0,1, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,0));
    rows.push_back(mk(1,1,16'h0222,16'h0333,0,0, 1,16'h0111,16'h0333, 1,16'h0111,16'h0333,0));
    rows.push_back(mk(0,1,16'h0000,16'h0444,1,0, 1,16'h0222,16'h0444, 1,16'h0222,16'h0444,0));
    rows.push_back(mk(0,0,16'h0000,16'h0000,1,0, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,0));
    rows.push_back(mk(1,0,16'h0555,16'h0000,0,0, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,0));
    rows.push_back(mk(0,1,16'h0000,16'h0666,0,0, 1,16'h0555,16'h0666, 1,16'h0555,16'h0666,0));
    rows.push_back(mk(1,0,16'h0777,16'h0000,0,0, 0,16'h0000,16'h0000, 1,16'h0555,16'h0666,0));
    rows.push_back(mk(0,1,16'h0000,16'h0888,0,1, 0,16'h0000,16'h0000, 1,16'h0555,16'h0666,1));
    rows.push_back(mk(0,0,16'h0000,16'h0000,1,0, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,1));
    rows.push_back(mk(0,0,16'h0000,16'h0000,0,1, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,0));

    // Reset with phi1 enabled: everything must still clear.
    repeat (3) @(posedge i_EMUCLK);
    #1;
    check("reset_outputs", {strobes(), o_LOCKED, o_SYNC_ERR, o_FRAME_VALID, o_OVERRUN,
                            o_FRAME_L, o_FRAME_R}, 64'd0);
    i_MRST_n = 1'b1;
    i_phi1_NCEN_n = 1'b1;

    // Lock sequence: first sync, 31 free-running steps, second on-time sync.
    phi_step(1'b1, 1'b0);
    check("first_sync_unlocked", {o_LOCKED, strobes()}, 64'd0);
    repeat (31) phi_step(1'b0, 1'b0);
    check("pre_second_sync_unlocked", {o_LOCKED, strobes()}, 64'd0);
    phi_step(1'b1, 1'b0);
    exp_cyc = 0;
    check("locked_after_second_sync", {o_LOCKED, strobes()}, {1'b1, exp_strobes(0)});

    cnt12 = 0; cnt_rng = 0;
    for (int k = 1; k <= 32; k++) begin
      phi_step(exp_cyc == 31, 1'b0);
      exp_cyc = (exp_cyc + 1) % 32;
      check($sformatf("strobe_cyc%0d", exp_cyc), {o_LOCKED, strobes()},
            {1'b1, exp_strobes(exp_cyc)});
      if (o_CYCLE_12) cnt12++;
      if (o_CYCLE_01_TO_16) cnt_rng++;
    end
    check("cycle12_count", cnt12, 1);
    check("cycle01_16_count", cnt_rng, 16);

    // Misplaced sync at cycle 20 with a same-cycle clear: the set must win.
    repeat (20) phi_step(1'b0, 1'b0);
    phi_step(1'b1, 1'b1);
    check("misplaced_sync", {o_SYNC_ERR, o_LOCKED, strobes()}, {2'b10, 5'd0});
    repeat (31) phi_step(1'b0, 1'b0);
    check("relocking_still_unlocked", {o_LOCKED, strobes()}, 64'd0);
    phi_step(1'b1, 1'b0);
    check("relocked", {o_SYNC_ERR, o_LOCKED, strobes()}, {2'b11, exp_strobes(0)});
    i_ERR_CLR = 1'b1;
    @(posedge i_EMUCLK); #1;
    i_ERR_CLR = 1'b0;
    check("err_clr", o_SYNC_ERR, 0);

    // A full period with no sync at all keeps lock and phase.
    repeat (32) phi_step(1'b0, 1'b0);
    check("missing_sync_tolerated", {o_LOCKED, strobes()}, {1'b1, exp_strobes(0)});

    // Frame handoff table (nothing strobed since reset, so no half-pair held).
    foreach (rows[i]) apply_row(rows[i], $sformatf("row%0d", i));

    // Reset while LOCKED with a frame pending and a half-pair held.
    check("pre_reset_locked", o_LOCKED, 1);
    apply_row(mk(1,0,16'h7777,16'h0000,0,0, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,0), "rst_l0");
    apply_row(mk(0,1,16'h0000,16'h7778,0,0, 1,16'h7777,16'h7778, 1,16'h7777,16'h7778,0), "rst_r0");
    apply_row(mk(1,0,16'h7779,16'h0000,0,0, 0,16'h0000,16'h0000, 1,16'h7777,16'h7778,0), "rst_l1");
    i_MRST_n = 1'b0;
    sb.delete();
    @(posedge i_EMUCLK); #1;
    check("midrun_reset_outputs", {strobes(), o_LOCKED, o_SYNC_ERR, o_FRAME_VALID, o_OVERRUN,
                                   o_FRAME_L, o_FRAME_R}, 64'd0);
    i_MRST_n = 1'b1;
    apply_row(mk(0,1,16'h0000,16'h0001,0,0, 0,16'h0000,16'h0000, 0,16'h0000,16'h0000,0),
              "post_reset_r_discarded");
    phi_step(1'b1, 1'b0);
    check("post_reset_fsm_unlocked", {o_LOCKED, o_SYNC_ERR}, 64'd0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ikaopm_acc_sequencer.md
# ikaopm_acc_sequencer

Cycle sequencer and stereo sample handoff for the R/L accumulator datapath. Runs a 32-step phi1 cycle counter that locks to an upstream frame-sync pulse, and decodes the registered cycle strobes that the accumulator and serial-output stages consume. It also pairs the accumulator's per-channel parallel sample strobes into stereo frames and hands them to a host-side consumer over a valid/ready handshake, with overrun detection.

## Interface
Parameters:
- `SYNC_LOCK_COUNT`, default 2. Number of consecutive well-placed sync pulses required before entering LOCKED. Legal range 1..7.

Ports:
- `i_EMUCLK`  in  1  emulator master clock, the only clock.
- `i_MRST_n`  in  1  reset. Synchronous, active-low.
- `i_phi1_NCEN_n`  in  1  phi1 negative-edge clock enable, active-low. Gates all cycle-counter logic.
- `i_CYCLE_SYNC`  in  1  upstream pulse, one phi1 cycle wide. It marks master cycle 31.
- `o_CYCLE_12`, `o_CYCLE_29`  out  1  high while the counter equals 12 or 29, respectively.
- `o_CYCLE_00_16`, `o_CYCLE_06_22`  out  1  high while the counter equals 0 or 16, and 6 or 22, respectively.
- `o_CYCLE_01_TO_16`  out  1  high while the counter is in 1..16 inclusive.
- `o_LOCKED`  out  1  high while the FSM is in LOCKED.
- `o_SYNC_ERR`  out  1  sticky. Set on a misplaced sync while LOCKED; cleared by reset or `i_ERR_CLR`.
- `i_ERR_CLR`  in  1  single-EMUCLK clear for `o_SYNC_ERR` and `o_OVERRUN`.
- `i_EMU_R_SAMPLE`, `i_EMU_L_SAMPLE`  in  1  single-EMUCLK strobes from the accumulator. They mark the data as valid.
- `i_EMU_R`, `i_EMU_L`  in  16 signed  parallel channel samples.
- `o_FRAME_VALID`  out  1  a stereo frame is available.
- `i_FRAME_READY`  in  1  the consumer accepts the frame.
- `o_FRAME_L`, `o_FRAME_R`  out  16 signed  frame payload.
- `o_OVERRUN`  out  1  sticky. Set when a completed frame is dropped.

## Operation
- Counter `cyc[4:0]`:
  - Advances on each EMUCLK edge where `!i_phi1_NCEN_n`.
  - Wraps 31→0.
- Sync FSM, evaluated on phi1-enabled edges only:
  - UNLOCKED: on `i_CYCLE_SYNC`, force `cyc`←0, `lock_cnt`←1, go to LOCKING. If `SYNC_LOCK_COUNT`==1, go directly to LOCKED.
  - LOCKING: on a sync with `cyc`==31, increment `lock_cnt`; at `SYNC_LOCK_COUNT` go to LOCKED. On a sync with `cyc`≠31, force `cyc`←0, `lock_cnt`←1 and stay in LOCKING.
  - LOCKED: a sync with `cyc`==31 is a no-op. A sync with `cyc`≠31 sets `o_SYNC_ERR`, forces `cyc`←0, `lock_cnt`←1 and goes to LOCKING.
  - Missing sync pulses are tolerated. The counter free-runs.
- Strobes:
  - Registered outputs, decoded from the next value of `cyc`, so each strobe is aligned to the phi1 period in which `cyc` holds that value.
  - All strobes are forced to 0 unless the FSM is LOCKED.
- Frame pairing runs every EMUCLK edge, not phi1-gated:
  - `i_EMU_L_SAMPLE`: latch `i_EMU_L` into `l_hold` and set `l_have`.
  - `i_EMU_R_SAMPLE` with `l_have`=1 produces a completed frame {`l_hold`, `i_EMU_R`}, and `l_have` clears. An R strobe with `l_have`=0 is discarded.
  - L and R strobes in the same cycle: the R strobe pairs with the old `l_hold`, and the new L is then latched for the next frame.
- Handshake:
  - Transfer occurs when `o_FRAME_VALID & i_FRAME_READY`. `o_FRAME_*` stay stable while valid and not ready.
  - If a frame completes while valid and not ready, the new frame is dropped, the old frame is kept and `o_OVERRUN` is set.
  - If a frame completes in the same cycle as a transfer, the new frame is loaded and `o_FRAME_VALID` stays 1. No overrun.
- `i_ERR_CLR` has lower priority than a same-cycle set, so the flag ends up set.

## Timing
- Reset values (applied regardless of `i_phi1_NCEN_n`):
  - all outputs 0;
  - `cyc`=0;
  - FSM = UNLOCKED;
  - `l_have`=0.
- Reset mid-frame discards any pending frame and half-pair.
- Strobe latency: when a sync is seen at cycle 31, `o_CYCLE_00_16` is high on the very next phi1 period, provided the FSM is already LOCKED.
- Frame latency: `o_FRAME_VALID` rises 1 EMUCLK after the completing R strobe.
- Throughput: one frame per 32 phi1 cycles nominal. The handshake tolerates a consumer stall of up to one frame period without loss.

## Structure
- Shared package `ikaopm_acc_pkg`:
  - FSM state enum (UNLOCKED, LOCKING, LOCKED);
  - cycle constants 0, 6, 12, 16, 22, 29, 31;
  - sample width 16.
- One sub-module, `ikaopm_acc_frame_handoff`, holding the pairing and valid/ready/overrun logic. The sequencer top holds the counter, FSM and strobe decode.

## Test plan
- Reset, then syncs every 32 phi1 cycles with `SYNC_LOCK_COUNT`=2 → `o_LOCKED` rises after the 2nd sync. `o_CYCLE_12` is high for exactly 1 phi1 period per 32. `o_CYCLE_01_TO_16` is high for 16.
- While LOCKED, inject a sync at `cyc`==20 → `o_SYNC_ERR`=1, `o_LOCKED`=0, strobes go low. The next on-time sync relocks. `i_ERR_CLR` clears the error flag.
- L=16'sh1234, then R=16'shFEDC, with ready held 1 → one frame {1234, FEDC}. VALID is high for 1 cycle.
- Ready held 0 across two complete frames → the first frame is held, `o_OVERRUN`=1, and the payload is unchanged after ready rises.
- R strobe first after reset, then L, then R → exactly one frame, pairing the later R.
- Assert `i_MRST_n`=0 mid-LOCKED with VALID=1 → all outputs 0 on the next EMUCLK and the FSM returns to UNLOCKED.
